// File: rtl/adc_ram_wr.sv
// Frame capture engine: fills a DEPTH-point sample RAM with decimated ADC samples,
// optionally starting on a rising crossing of a trigger level, then holds wr_done.
module adc_ram_wr #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic [15:0]       decim,
  input  logic              trig_en,
  input  logic [DATA_W-1:0] trig_level,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              busy,
  output logic              wr_done
);

  typedef enum logic [1:0] {IDLE, ARM, FILL, DONE} state_t;

  state_t              state;
  logic [15:0]         decim_q;
  logic [15:0]         dcnt;
  logic [DATA_W-1:0]   level_q;
  logic [DATA_W-1:0]   prev;
  logic                prev_valid;
  logic [ADDR_W-1:0]   cnt;

  // One-entry stage between the accept decision and the RAM write port.
  logic                pend;
  logic                pend_last;
  logic [ADDR_W-1:0]   pend_addr;
  logic [DATA_W-1:0]   pend_data;

  logic                crossing;
  logic                accept;
  logic                last_accept;
  logic [15:0]         dcnt_next;

  assign crossing    = prev_valid && (prev < level_q) && (adc_data >= level_q);
  assign accept      = adc_valid && (((state == ARM) && crossing) ||
                                     ((state == FILL) && (dcnt == '0)));
  assign last_accept = accept && (cnt == ADDR_W'(DEPTH - 1));
  assign dcnt_next   = (dcnt == decim_q) ? '0 : dcnt + 16'd1;

  // NOTE: every register here is sequential state, so only non-blocking
  // assignments are used; blocking ones would make later reads in this block
  // see the new value and break the one-cycle accept-to-write pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      decim_q    <= '0;
      dcnt       <= '0;
      level_q    <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
      cnt        <= '0;
      pend       <= 1'b0;
      pend_last  <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
      ram_we     <= 1'b0;
      ram_waddr  <= '0;
      ram_wdata  <= '0;
      busy       <= 1'b0;
      wr_done    <= 1'b0;
    end else if (start) begin
      // start wins over everything, including an accept or a pending write.
      decim_q    <= decim;
      level_q    <= trig_level;
      dcnt       <= '0;
      cnt        <= '0;
      prev_valid <= 1'b0;
      pend       <= 1'b0;
      pend_last  <= 1'b0;
      ram_we     <= 1'b0;
      wr_done    <= 1'b0;
      busy       <= 1'b1;
      state      <= trig_en ? ARM : FILL;
    end else begin
      ram_we <= pend;
      if (pend) begin
        ram_waddr <= pend_addr;
        ram_wdata <= pend_data;
        if (pend_last) begin
          wr_done <= 1'b1;
          busy    <= 1'b0;
        end
      end

      pend      <= accept;
      pend_last <= last_accept;
      if (accept) begin
        pend_addr <= cnt;
        pend_data <= adc_data;
        cnt       <= cnt + 1'b1;
      end

      unique case (state)
        ARM: begin
          if (adc_valid) begin
            prev       <= adc_data;
            prev_valid <= 1'b1;
            if (crossing) begin
              // The trigger sample counts as the first kept sample.
              state <= last_accept ? DONE : FILL;
              dcnt  <= 16'(decim_q != '0);
            end
          end
        end
        FILL: begin
          if (adc_valid) begin
            dcnt <= dcnt_next;
            if (last_accept) state <= DONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
